cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_pkg.sv | 12 +
 rtl/cache_array.sv | 44 ++++
 rtl/cache_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller.
package cache_controller_pkg;

  localparam int INDEX_BITS_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_MISS  = 2'd1,
    WRITE_THRU = 2'd2
  } state_e;

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: one synchronous write port, one combinational read port.
module cache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 32 - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [31:0]           rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [31:0]           wr_data_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Only the valid bits need reset; stale tags/data are masked by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, one-word-line cache between the MEM stage and an SRAM controller.
// Write-through, no-write-allocate; read hits complete combinationally.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_readData,
  input  logic        sram_ready
);

  localparam int TAG_W = 32 - INDEX_BITS - 2;

  state_e state_q, state_d;
  logic   done_q, done_d;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line_data;
  logic                  hit;
  logic                  is_write;

  logic        arr_we;
  logic [31:0] arr_wdata;
  logic        r_en, w_en;

  assign index    = address[INDEX_BITS+1:2];
  assign tag      = address[31:INDEX_BITS+2];
  assign hit      = line_valid && (line_tag == tag);
  assign is_write = MEM_W_EN;

  cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst),
    .rd_index_i (index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (arr_we),
    .wr_index_i (index),
    .wr_tag_i   (tag),
    .wr_data_i  (arr_wdata)
  );

  // done_q marks the cycle after an SRAM completion, when no new SRAM request may start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b1;
    readData  = 32'd0;
    r_en      = 1'b0;
    w_en      = 1'b0;
    arr_we    = 1'b0;
    arr_wdata = sram_readData;
    done_d    = (state_q != IDLE) && sram_ready;
    case (state_q)
      IDLE: begin
        if (is_write) begin
          ready = 1'b0;
          if (!done_q) begin
            w_en    = 1'b1;
            state_d = WRITE_THRU;
          end
        end else if (MEM_R_EN) begin
          if (hit) begin
            readData = line_data;
          end else begin
            ready = 1'b0;
            if (!done_q) begin
              r_en    = 1'b1;
              state_d = READ_MISS;
            end
          end
        end
      end
      READ_MISS: begin
        r_en  = 1'b1;
        ready = sram_ready;
        if (sram_ready) begin
          readData = sram_readData;
          arr_we   = 1'b1;
          state_d  = IDLE;
        end
      end
      WRITE_THRU: begin
        w_en      = 1'b1;
        ready     = sram_ready;
        arr_wdata = writeData;
        if (sram_ready) begin
          arr_we  = hit;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset must silence the SRAM even while a request is still presented.
  assign sram_r_en    = r_en & rst;
  assign sram_w_en    = w_en & rst;
  assign sram_address = address;
  assign sram_wdata   = writeData;

endmodule
